// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_stage_pc_next.sv
// Next-PC selection: redirect target, hold, or sequential +4.
module pc_next
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  fetch_state_e    state,
    input  logic            stall,
    output logic [XLEN-1:0] pc_nxt,
    output logic [XLEN-1:0] pc_plus4,
    output logic            target_misaligned
);

    assign pc_plus4          = pc + XLEN'(4);
    assign target_misaligned = |redirect_pc[1:0];

    // Priority: redirect > fault hold > stall hold > sequential.
    // A misaligned redirect keeps the current PC.
    always_comb begin
        pc_nxt = pc_plus4;
        if (redirect) begin
            pc_nxt = target_misaligned ? pc : redirect_pc;
        end else if (state == FAULT) begin
            pc_nxt = pc;
        end else if (stall) begin
            pc_nxt = pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register,
// FETCH/FAULT state machine and a fetch counter.
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic [XLEN-1:0] rom_rd_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            fetch_fault_o,
    output logic [XLEN-1:0] fetch_cnt_o
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc, pc_d, pc_plus4;
    logic            misaligned;
    if_id_t          if_id, if_id_d;
    logic            fault, fault_d;
    logic [XLEN-1:0] cnt, cnt_d;

    pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc                (pc),
        .redirect          (redirect_i),
        .redirect_pc       (redirect_pc_i),
        .state             (state),
        .stall             (stall_i),
        .pc_nxt            (pc_d),
        .pc_plus4          (pc_plus4),
        .target_misaligned (misaligned)
    );

    // Next-state, IF/ID, fault flag and counter selection.
    always_comb begin
        state_d = state;
        if_id_d = if_id;
        fault_d = fault;
        cnt_d   = cnt;
        if (redirect_i) begin
            // squash keeps the previous pc/pc4 in IF/ID
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            if (misaligned) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = FETCH;
                fault_d = 1'b0;
            end
        end else if (state == FAULT) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (!stall_i) begin
            if_id_d.valid = 1'b1;
            if_id_d.pc    = pc;
            if_id_d.pc4   = pc_plus4;
            if_id_d.instr = rom_rd_i;
            cnt_d         = cnt + XLEN'(1);
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            if_id <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};
            fault <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if_id <= if_id_d;
            fault <= fault_d;
            cnt   <= cnt_d;
        end
    end

    assign rom_addr_o    = pc;
    assign if_id_valid_o = if_id.valid;
    assign if_id_pc_o    = if_id.pc;
    assign if_id_pc4_o   = if_id.pc4;
    assign if_id_instr_o = if_id.instr;
    assign fetch_fault_o = fault;
    assign fetch_cnt_o   = cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a scoreboard of expected IF/ID contents.
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic [31:0] rom_addr, rom_rd, id_pc, id_pc4, id_instr, cnt;
    logic        id_valid, fault;

    logic [31:0] rom_addr_b, rom_rd_b, id_pc_b, id_pc4_b, id_instr_b, cnt_b;
    logic        id_valid_b, fault_b;

    int unsigned checks = 0;
    int unsigned fails  = 0;
    if_id_t      sb[$];

    // ROM: word i at byte address i*4 holds value i
    assign rom_rd   = {2'b00, rom_addr[31:2]};
    assign rom_rd_b = {2'b00, rom_addr_b[31:2]};

    always #5 clk = ~clk;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .rom_addr_o(rom_addr), .rom_rd_i(rom_rd),
        .if_id_valid_o(id_valid), .if_id_pc_o(id_pc), .if_id_pc4_o(id_pc4),
        .if_id_instr_o(id_instr), .fetch_fault_o(fault), .fetch_cnt_o(cnt)
    );

    if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .rom_addr_o(rom_addr_b), .rom_rd_i(rom_rd_b),
        .if_id_valid_o(id_valid_b), .if_id_pc_o(id_pc_b), .if_id_pc4_o(id_pc4_b),
        .if_id_instr_o(id_instr_b), .fetch_fault_o(fault_b), .fetch_cnt_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected IF/ID, advance one edge, pop and compare.
    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] p4,
                        input logic [31:0] ins, input string tag);
        if_id_t e, o;
        sb.push_back('{valid: v, pc: p, pc4: p4, instr: ins});
        tick();
        e = sb.pop_front();
        o = '{valid: id_valid, pc: id_pc, pc4: id_pc4, instr: id_instr};
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got v=%b pc=%h pc4=%h ins=%h expected v=%b pc=%h pc4=%h ins=%h",
                   tag, o.valid, o.pc, o.pc4, o.instr, e.valid, e.pc, e.pc4, e.instr);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  rom_addr, 32'h0);
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, "_pc"},    id_pc, 32'h0);
        chk({tag, "_pc4"},   id_pc4, 32'h0);
        chk({tag, "_instr"}, id_instr, 32'h0000_0013);
        chk({tag, "_fault"}, {31'b0, fault}, 32'h0);
        chk({tag, "_cnt"},   cnt, 32'h0);
        chk({tag, "_addr_b"}, rom_addr_b, 32'hFFFF_FFFC);
    endtask

    initial begin
        #12;
        chk_reset("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // free-running fetch from reset
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 32'(i * 4), 32'(i * 4 + 4), 32'(i), "seq");
            if (i == 0) begin
                chk("wrap_addr", rom_addr_b, 32'h0);
                chk("wrap_pc4",  id_pc4_b, 32'h0);
                chk("wrap_pc",   id_pc_b, 32'hFFFF_FFFC);
                chk("wrap_ins",  id_instr_b, 32'h3FFF_FFFF);
            end
        end
        chk("seq_cnt",  cnt, 32'd256);
        chk("seq_addr", rom_addr, 32'h400);

        // restart and stall at pc=0x10
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(i * 4), 32'(i * 4 + 4), 32'(i), "pre_stall");
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'hC, 32'h10, 32'd3, "stall_hold");
            chk("stall_addr", rom_addr, 32'h10);
            chk("stall_cnt",  cnt, 32'd4);
        end
        stall = 1'b0;
        step(1'b1, 32'h10, 32'h14, 32'd4, "stall_resume");
        chk("resume_cnt", cnt, 32'd5);

        // redirect together with stall
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        step(1'b0, 32'h10, 32'h14, 32'h13, "redir_squash");
        chk("redir_addr", rom_addr, 32'h40);
        chk("redir_cnt",  cnt, 32'd5);
        redirect = 1'b0; stall = 1'b0;
        step(1'b1, 32'h40, 32'h44, 32'd16, "redir_fetch");
        chk("redir_cnt2", cnt, 32'd6);

        // misaligned redirect enters FAULT
        redirect = 1'b1; redirect_pc = 32'h42;
        step(1'b0, 32'h40, 32'h44, 32'h13, "fault_enter");
        chk("fault_flag", {31'b0, fault}, 32'h1);
        chk("fault_addr", rom_addr, 32'h44);
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 32'h40, 32'h44, 32'h13, "fault_hold");
            chk("fault_sticky", {31'b0, fault}, 32'h1);
            chk("fault_cnt", cnt, 32'd6);
            chk("fault_addr_hold", rom_addr, 32'h44);
        end
        redirect = 1'b1; redirect_pc = 32'h81;
        step(1'b0, 32'h40, 32'h44, 32'h13, "fault_misal_again");
        chk("fault_still", {31'b0, fault}, 32'h1);
        chk("fault_addr_mis", rom_addr, 32'h44);
        redirect_pc = 32'h80;
        step(1'b0, 32'h40, 32'h44, 32'h13, "fault_exit");
        chk("fault_clear", {31'b0, fault}, 32'h0);
        chk("fault_exit_addr", rom_addr, 32'h80);
        redirect = 1'b0;
        step(1'b1, 32'h80, 32'h84, 32'd32, "post_fault");
        chk("post_fault_cnt", cnt, 32'd7);

        // asynchronous reset mid-stall, observed before the next edge
        stall = 1'b1;
        step(1'b1, 32'h80, 32'h84, 32'd32, "pre_async");
        #2 rst = 1'b1;
        #1;
        chk_reset("async");
        rst = 1'b0;
        stall = 1'b0;
        step(1'b1, 32'h0, 32'h4, 32'd0, "after_async");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
